x_pmcd_gen2: RTL and testbench
==============================

// Module: x_pmcd_gen2
// PURPOSE
//   Parametrised phase-matched clock-enable divider, the next generation of the fixed /1,/2,/4,/8 PMCD.
//   Derives NUM_CH divided enables and 50%-style divided levels from one clock.
//   All channels restart together, so they stay phase-matched.
//   Supports optional release gating and a req/ack handshake for glitch-free ratio reload at a common phase.
//   Sits between clock/reset generation and the multi-rate datapath blocks.
// PARAMETERS
//   NUM_CH    4              number of divider channels (1..16)
//   CNT_W     8              ratio/counter width per channel (2..16)
//   EN_REL    "FALSE"        "TRUE": hold outputs after reset until REL seen high
//   DIV_INIT  32'h08040201   reset ratios, channel k at bits [k*CNT_W +: CNT_W]
// PORTS
//   CLK        in   1             single clock, all logic rising-edge
//   RST_N      in   1             asynchronous active-low reset
//   REL        in   1             release; level-sampled, used only when EN_REL="TRUE"
//   DIV        in   NUM_CH*CNT_W  new ratios; must be stable while LOAD_REQ=1
//   LOAD_REQ   in   1             ratio reload request (4-phase)
//   LOAD_ACK   out  1             reload applied; held until LOAD_REQ low
//   CE         out  NUM_CH        one-cycle enable per channel at terminal count
//   DCLK       out  NUM_CH        divided level per channel
//   ALIGN      out  1             high when every CE bit is high in the same cycle
//   RUNNING    out  1             high while dividers count
// BEHAVIOUR
//   Effective ratio R_k = DIV field value; a field value of 0 is treated as 1.
//   Counter cnt_k counts 0..R_k-1 and then wraps to 0.
//   Outputs decode only registered state; there is no combinational path from any input to any output.
//   CE[k]   = RUNNING & (cnt_k == R_k-1).
//   DCLK[k] = RUNNING & (cnt_k < ceil(R_k/2)).
//   R=1: CE=1 and DCLK=1 every RUN cycle. Odd R: DCLK is high for one more cycle than it is low.
//   ALIGN = &CE.
//   States:
//     HOLD  async reset state; cnt=0, ratios=DIV_INIT.
//     WREL  waiting for REL.
//     RUN   counting.
//     PEND  new ratios captured, waiting for the common phase.
//     ACK   new ratios applied, waiting for LOAD_REQ low.
//   HOLD->RUN on the first clock after RST_N deasserts if EN_REL="FALSE"; otherwise HOLD->WREL.
//   WREL->RUN on the clock where REL=1.
//   On entry to RUN, all cnt=0. The first cycle with RUNNING=1 has cnt=0, so CE[k] first fires at RUN cycle R_k.
//   RUN, LOAD_REQ=1: capture DIV into shadow; go to PEND. Counting continues on the old ratios.
//   PEND: on the cycle where cnt_0 == R_0-1 (old ratio), CE still fires per the old ratios.
//     Next cycle: all cnt=0, new ratios active, LOAD_ACK=1, state ACK.
//   ACK: counting continues. When LOAD_REQ=0 is sampled: LOAD_ACK=0 next cycle, go to RUN.
//   LOAD_REQ is ignored in HOLD/WREL/PEND, and a new request is not accepted until the ACK phase completes.
//   REL is ignored outside WREL. Toggling DIV without LOAD_REQ has no effect.
//   Reset values: CE=0, DCLK=0, ALIGN=0, RUNNING=0, LOAD_ACK=0, state HOLD, shadow ratios=DIV_INIT.
//   RST_N low at any time, including during PEND/ACK: all of the above apply immediately; the pending reload is discarded.
//   Counters never exceed R_k-1; R=2^CNT_W-1 wraps with no overflow.
// TESTING
//   1 EN_REL="FALSE", defaults, release reset:
//     RUNNING=1 at cycle 1; CE0 every cycle; CE1 at cycles 2,4; CE3 at 8,16; ALIGN at 8,16.
//   2 EN_REL="TRUE": RUNNING, CE and DCLK stay 0 for 20 cycles; REL=1 at cycle 21 -> RUNNING=1 at cycle 22, CE3 first at cycle 29.
//   3 Reload DIV={7,6,5,3} (ch3..ch0) with old R_0=1: LOAD_ACK=1 two cycles after the LOAD_REQ sample;
//     from the restart cycle, CE0 period is 3 and CE3 period is 7; drop LOAD_REQ -> LOAD_ACK=0 next cycle.
//   4 Odd/zero ratios: R=3 -> DCLK pattern 1,1,0 repeating; field value 0 -> CE and DCLK constantly 1.
//   5 Pull RST_N low while in PEND:
//     outputs go to 0 asynchronously; after release, ratios are 1,2,4,8 again and LOAD_ACK=0.
//   6 CNT_W=8, R=255: CE fires every 255 cycles across 3 periods; DCLK high 128, low 127.

Source files
------------

// File: rtl/x_pmcd_gen2_if.sv
// x_pmcd_gen2_if
//   Bundle of the non-clock signals of the phase-matched clock-enable divider.
//   master : the controller that drives release, new ratios and reload requests
//   slave  : the divider itself
//   Signals
//     rel      release level, only looked at while the divider waits for release
//     div      new ratio per channel, channel k in div[k]
//     loadReq  four-phase reload request
//     loadAck  reload applied, held until loadReq drops
//     ce       one-cycle enable per channel at terminal count
//     dclk     divided level per channel
//     align    every ce bit high in the same cycle
//     running  dividers are counting
`timescale 1ns/1ps
interface x_pmcd_gen2_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
);
    logic                             rel;
    logic [NUM_CH-1:0][CNT_W-1:0]     div;
    logic                             loadReq;
    logic                             loadAck;
    logic [NUM_CH-1:0]                ce;
    logic [NUM_CH-1:0]                dclk;
    logic                             align;
    logic                             running;

    modport master (
        output rel, div, loadReq,
        input  loadAck, ce, dclk, align, running
    );

    modport slave (
        input  rel, div, loadReq,
        output loadAck, ce, dclk, align, running
    );
endinterface

// File: rtl/x_pmcd_gen2.sv
// x_pmcd_gen2
//   Parametrised phase-matched clock-enable divider. NUM_CH counters share one
//   restart point so their enables and divided levels stay phase-matched. New
//   ratios are loaded through a four-phase req/ack handshake and applied at the
//   common phase where channel 0 reaches its terminal count.
//   Ports
//     clk_i   single rising-edge clock
//     rst_ni  asynchronous active-low reset
//     bus_if  slave side of x_pmcd_gen2_if (rel, div, loadReq in;
//             loadAck, ce, dclk, align, running out)
`timescale 1ns/1ps
module x_pmcd_gen2 #(
    parameter int                          NUM_CH   = 4,
    parameter int                          CNT_W    = 8,
    parameter string                       EN_REL   = "FALSE",
    parameter logic [NUM_CH*CNT_W-1:0]     DIV_INIT = (NUM_CH*CNT_W)'(32'h08040201)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    x_pmcd_gen2_if.slave     bus_if
);

    localparam bit RelGate = (EN_REL == "TRUE");

    typedef enum logic [2:0] {HOLD, WREL, RUN, PEND, ACK} state_t;
    typedef logic [NUM_CH-1:0][CNT_W-1:0] ratioVec_t;

    state_t             state_q, state_d;
    ratioVec_t          cnt_q, cnt_d;
    ratioVec_t          ratio_q, ratio_d;
    ratioVec_t          shadow_q, shadow_d;
    logic               loadAck_q, loadAck_d;
    logic [NUM_CH-1:0]  ce_q, ce_d;
    logic [NUM_CH-1:0]  dclk_q, dclk_d;
    logic               align_q, align_d;
    logic               running_q, running_d;

    // A ratio field of zero behaves as a ratio of one, so its terminal count is 0.
    function automatic logic [CNT_W-1:0] termCount(input logic [CNT_W-1:0] field);
        termCount = (field == '0) ? '0 : field - CNT_W'(1);
    endfunction

    // Number of high cycles of the divided level: ceil(R/2), one extra bit so
    // that R = 2^CNT_W-1 does not overflow.
    function automatic logic [CNT_W:0] highLen(input logic [CNT_W-1:0] field);
        logic [CNT_W:0] r;
        r       = (field == '0) ? (CNT_W+1)'(1) : {1'b0, field};
        highLen = (r + (CNT_W+1)'(1)) >> 1;
    endfunction

    // Next-state logic. Counters free-run on the active ratios; the state
    // machine overrides them with zero while idle and at the reload phase.
    // The registered outputs are decoded from the next state so they line up
    // with the counters they describe and never see an input combinationally.
    always_comb begin
        state_d   = state_q;
        ratio_d   = ratio_q;
        shadow_d  = shadow_q;
        loadAck_d = loadAck_q;
        for (int k = 0; k < NUM_CH; k++) begin
            cnt_d[k] = (cnt_q[k] == termCount(ratio_q[k])) ? '0 : cnt_q[k] + CNT_W'(1);
        end

        case (state_q)
            HOLD: begin
                cnt_d   = '0;
                state_d = RelGate ? WREL : RUN;
            end
            WREL: begin
                cnt_d = '0;
                if (bus_if.rel) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus_if.loadReq) begin
                    shadow_d = bus_if.div;
                    state_d  = PEND;
                end
            end
            PEND: begin
                if (cnt_q[0] == termCount(ratio_q[0])) begin
                    cnt_d     = '0;
                    ratio_d   = shadow_q;
                    loadAck_d = 1'b1;
                    state_d   = ACK;
                end
            end
            ACK: begin
                if (!bus_if.loadReq) begin
                    loadAck_d = 1'b0;
                    state_d   = RUN;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = HOLD;
            end
        endcase

        running_d = (state_d == RUN) || (state_d == PEND) || (state_d == ACK);
        for (int k = 0; k < NUM_CH; k++) begin
            ce_d[k]   = running_d && (cnt_d[k] == termCount(ratio_d[k]));
            dclk_d[k] = running_d && ({1'b0, cnt_d[k]} < highLen(ratio_d[k]));
        end
        align_d = &ce_d;
    end

    // State and output registers. Reset drops every output at once and throws
    // away any reload that was in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= HOLD;
            cnt_q     <= '0;
            ratio_q   <= DIV_INIT;
            shadow_q  <= DIV_INIT;
            loadAck_q <= 1'b0;
            ce_q      <= '0;
            dclk_q    <= '0;
            align_q   <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ratio_q   <= ratio_d;
            shadow_q  <= shadow_d;
            loadAck_q <= loadAck_d;
            ce_q      <= ce_d;
            dclk_q    <= dclk_d;
            align_q   <= align_d;
            running_q <= running_d;
        end
    end

    assign bus_if.loadAck = loadAck_q;
    assign bus_if.ce      = ce_q;
    assign bus_if.dclk    = dclk_q;
    assign bus_if.align   = align_q;
    assign bus_if.running = running_q;

endmodule

// File: tb/tb_x_pmcd_gen2.sv
// tb_x_pmcd_gen2
//   Bench for x_pmcd_gen2. Instance dutA runs without release gating and is
//   followed cycle by cycle by a reference model that works from the elapsed
//   run time since the last restart; dutB uses release gating and is checked
//   with directed expectations.
`timescale 1ns/1ps
module tb_x_pmcd_gen2;

    localparam int NCH = 4;
    localparam int CW  = 8;

    typedef logic [NCH-1:0][CW-1:0] divVec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    x_pmcd_gen2_if #(.NUM_CH(NCH), .CNT_W(CW)) busA ();
    x_pmcd_gen2_if #(.NUM_CH(NCH), .CNT_W(CW)) busB ();

    x_pmcd_gen2 #(.NUM_CH(NCH), .CNT_W(CW), .EN_REL("FALSE")) dutA (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus_if (busA)
    );

    x_pmcd_gen2 #(.NUM_CH(NCH), .CNT_W(CW), .EN_REL("TRUE")) dutB (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus_if (busB)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: elapsed run cycles since the last restart plus the
    // ratio sets, with the handshake tracked as plain flags.
    bit mRunning;
    bit mPend;
    bit mAck;
    int mT;
    int mR[NCH];
    int mShadow[NCH];

    function automatic int effR(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Model update at every active edge, with the same asynchronous reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mRunning = 1'b0;
            mPend    = 1'b0;
            mAck     = 1'b0;
            mT       = 0;
            mR       = '{1, 2, 4, 8};
            mShadow  = '{1, 2, 4, 8};
        end else if (!mRunning) begin
            mRunning = 1'b1;
            mT       = 0;
        end else if (mPend && ((mT % effR(mR[0])) == effR(mR[0]) - 1)) begin
            mT    = 0;
            mR    = mShadow;
            mPend = 1'b0;
            mAck  = 1'b1;
        end else begin
            mT++;
            if (mAck) begin
                if (!busA.loadReq) mAck = 1'b0;
            end else if (!mPend && busA.loadReq) begin
                for (int k = 0; k < NCH; k++) mShadow[k] = int'(busA.div[k]);
                mPend = 1'b1;
            end
        end
    end

    task automatic checkModel();
        logic [NCH-1:0] eCe;
        logic [NCH-1:0] eDclk;
        int r;
        int ph;
        for (int k = 0; k < NCH; k++) begin
            r        = effR(mR[k]);
            ph       = mT % r;
            eCe[k]   = mRunning && (ph == r - 1);
            eDclk[k] = mRunning && (ph < (r + 1) / 2);
        end
        checkOutput("mdlCe",      32'(busA.ce),      32'(eCe));
        checkOutput("mdlDclk",    32'(busA.dclk),    32'(eDclk));
        checkOutput("mdlAlign",   32'(busA.align),   32'(&eCe));
        checkOutput("mdlRunning", 32'(busA.running), 32'(mRunning));
        checkOutput("mdlAck",     32'(busA.loadAck), 32'(mAck));
    endtask

    // Advance to mid-cycle of the next clock period and compare against the model.
    task automatic tick();
        @(negedge clk);
        checkModel();
    endtask

    task automatic applyStimulus(input logic req, input divVec_t divVec);
        busA.loadReq = req;
        busA.div     = divVec;
        busA.rel     = 1'($urandom_range(0, 1));
    endtask

    function automatic divVec_t randomDiv();
        divVec_t v;
        for (int k = 0; k < NCH; k++) v[k] = CW'($urandom_range(0, 12));
        return v;
    endfunction

    task automatic doReload(input divVec_t newDiv, input int holdCycles);
        int waitCnt;
        applyStimulus(1'b1, newDiv);
        waitCnt = 0;
        do begin
            tick();
            waitCnt++;
        end while (busA.loadAck !== 1'b1 && waitCnt < 600);
        if (busA.loadAck !== 1'b1) checkOutput("ackRiseTimeout", 32'(busA.loadAck), 32'd1);
        repeat (holdCycles) tick();
        applyStimulus(1'b0, newDiv);
        tick();
        checkOutput("ackFall", 32'(busA.loadAck), 32'd0);
    endtask

    initial begin
        divVec_t divVec;
        int waitCnt;
        int ce0Count;
        int firstCe;
        int hi;
        int lo;

        busA.rel = 1'b0; busA.div = '0; busA.loadReq = 1'b0;
        busB.rel = 1'b0; busB.div = '0; busB.loadReq = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk);
        checkOutput("rstRunning", 32'(busA.running), 32'd0);
        checkOutput("rstCe",      32'(busA.ce),      32'd0);
        checkOutput("rstDclk",    32'(busA.dclk),    32'd0);
        checkOutput("rstAck",     32'(busA.loadAck), 32'd0);
        checkOutput("rstAlign",   32'(busA.align),   32'd0);
        checkOutput("rstRunB",    32'(busB.running), 32'd0);
        rst_n = 1'b1;

        // Default ratios 1,2,4,8 on dutA; release gating on dutB.
        for (int n = 1; n <= 30; n++) begin
            tick();
            if (n == 1) checkOutput("t1Running", 32'(busA.running), 32'd1);
            if (n <= 16) begin
                checkOutput("t1Ce0",   32'(busA.ce[0]), 32'd1);
                checkOutput("t1Ce1",   32'(busA.ce[1]), 32'(n % 2 == 0));
                checkOutput("t1Ce3",   32'(busA.ce[3]), 32'(n % 8 == 0));
                checkOutput("t1Align", 32'(busA.align), 32'(n % 8 == 0));
            end
            if (n <= 21) begin
                checkOutput("t2RunB",  32'(busB.running), 32'd0);
                checkOutput("t2CeB",   32'(busB.ce),      32'd0);
                checkOutput("t2DclkB", 32'(busB.dclk),    32'd0);
            end else begin
                checkOutput("t2RunB",  32'(busB.running), 32'd1);
                checkOutput("t2Ce3B",  32'(busB.ce[3]),   32'(n == 29));
            end
            busB.rel = (n == 21);
            busA.rel = 1'($urandom_range(0, 1));
        end

        // Reload {7,6,5,3} from old R0 = 1.
        divVec[0] = 8'd3; divVec[1] = 8'd5; divVec[2] = 8'd6; divVec[3] = 8'd7;
        applyStimulus(1'b1, divVec);
        tick();
        checkOutput("t3AckEarly", 32'(busA.loadAck), 32'd0);
        tick();
        checkOutput("t3AckSet", 32'(busA.loadAck), 32'd1);
        for (int t = 0; t <= 20; t++) begin
            if (t > 0) tick();
            checkOutput("t3Ce0",   32'(busA.ce[0]),   32'(t % 3 == 2));
            checkOutput("t4Dclk0", 32'(busA.dclk[0]), 32'(t % 3 < 2));
            checkOutput("t3Ce3",   32'(busA.ce[3]),   32'(t % 7 == 6));
        end
        applyStimulus(1'b0, divVec);
        checkOutput("t3AckHeld", 32'(busA.loadAck), 32'd1);
        tick();
        checkOutput("t3AckDrop", 32'(busA.loadAck), 32'd0);

        // Zero field on channel 1 acts as ratio 1.
        divVec[0] = 8'd3; divVec[1] = 8'd0; divVec[2] = 8'd4; divVec[3] = 8'd8;
        doReload(divVec, 2);
        for (int t = 0; t < 10; t++) begin
            tick();
            checkOutput("t4Ce1Zero",   32'(busA.ce[1]),   32'd1);
            checkOutput("t4Dclk1Zero", 32'(busA.dclk[1]), 32'd1);
        end

        // Randomized reloads with idle stretches where DIV wanders without a request.
        for (int it = 0; it < 25; it++) begin
            for (int i = 0; i < int'($urandom_range(1, 30)); i++) begin
                applyStimulus(1'b0, randomDiv());
                tick();
            end
            doReload(randomDiv(), int'($urandom_range(0, 4)));
        end

        // Ratio 255 on every channel across three periods.
        for (int k = 0; k < NCH; k++) divVec[k] = 8'd255;
        applyStimulus(1'b1, divVec);
        waitCnt = 0;
        do begin
            tick();
            waitCnt++;
        end while (busA.loadAck !== 1'b1 && waitCnt < 600);
        if (busA.loadAck !== 1'b1) checkOutput("t6AckTimeout", 32'(busA.loadAck), 32'd1);
        ce0Count = 0; firstCe = -1; hi = 0; lo = 0;
        for (int t = 0; t < 765; t++) begin
            if (t > 0) tick();
            if (busA.ce[0]) begin
                ce0Count++;
                if (firstCe < 0) firstCe = t;
            end
            if (t < 255) begin
                if (busA.dclk[0]) hi++;
                else lo++;
            end
        end
        checkOutput("t6CeCount", 32'(ce0Count), 32'd3);
        checkOutput("t6FirstCe", 32'(firstCe),  32'd254);
        checkOutput("t6DclkHi",  32'(hi),       32'd128);
        checkOutput("t6DclkLo",  32'(lo),       32'd127);
        applyStimulus(1'b0, divVec);
        tick();
        checkOutput("t6AckDrop", 32'(busA.loadAck), 32'd0);

        // Reset while a reload is pending.
        applyStimulus(1'b1, randomDiv());
        tick();
        checkOutput("t5PreRunning", 32'(busA.running), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t5AsyncRunning", 32'(busA.running), 32'd0);
        checkOutput("t5AsyncCe",      32'(busA.ce),      32'd0);
        checkOutput("t5AsyncDclk",    32'(busA.dclk),    32'd0);
        checkOutput("t5AsyncAck",     32'(busA.loadAck), 32'd0);
        checkOutput("t5AsyncAlign",   32'(busA.align),   32'd0);
        applyStimulus(1'b0, randomDiv());
        tick();
        tick();
        rst_n = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            tick();
            checkOutput("t5Ce0", 32'(busA.ce[0]),   32'd1);
            checkOutput("t5Ce1", 32'(busA.ce[1]),   32'(n % 2 == 0));
            checkOutput("t5Ce3", 32'(busA.ce[3]),   32'(n % 8 == 0));
            checkOutput("t5Ack", 32'(busA.loadAck), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
